pixel_fetch: RTL

Parametrised frame-buffer read path that converts a pixel address into a packed-word memory read and returns the selected pixel. It sits between the VGA scan-out address generator and the frame-buffer RAM. It extends the fixed 4-bit, 16-bit-word select with configurable pixel and word widths, a configurable memory read latency and a selectable packing order. It also keeps a one-word cache so consecutive pixels from the same word cost no RAM read, and uses valid/ready handshakes on both the request and pixel sides.

---
 rtl/fb_pkg.sv | 28 ++
 rtl/pixel_slice.sv | 19 +
 rtl/pixel_fetch.sv | 117 +++++++++++
 3 files changed

// File: rtl/fb_pkg.sv
// Shared types and helpers for the frame-buffer pixel read path.
// The slot-select function is the single definition of the packing order.
package fb_pkg;

  typedef enum logic {READY, WAIT} pix_fetch_state_t;

  localparam int MAX_WORD_W = 64;

  function automatic int sel_width(input int word_w, input int pix_w);
    return $clog2(word_w / pix_w);
  endfunction

  // Returns the selected pixel right-aligned, upper bits zero.
  function automatic logic [MAX_WORD_W-1:0] slot_select(
    input logic [MAX_WORD_W-1:0] word,
    input int                    slot,
    input int                    pix_w,
    input int                    ppw,
    input bit                    lsb_first
  );
    int                    idx;
    logic [MAX_WORD_W-1:0] mask;
    idx  = lsb_first ? slot : (ppw - 1 - slot);
    mask = (pix_w >= MAX_WORD_W) ? '1 : ((64'd1 << pix_w) - 64'd1);
    return (word >> (idx * pix_w)) & mask;
  endfunction

endpackage

// File: rtl/pixel_slice.sv
// Combinational word + slot -> pixel extraction for a packed frame-buffer word.
module pixel_slice
  import fb_pkg::*;
#(
  parameter int WORD_W    = 16,
  parameter int PIX_W     = 4,
  parameter bit LSB_FIRST = 1'b1,
  localparam int SEL_W    = sel_width(WORD_W, PIX_W)
) (
  input  logic [WORD_W-1:0] word,
  input  logic [SEL_W-1:0]  slot,
  output logic [PIX_W-1:0]  pixel
);

  localparam int PPW = WORD_W / PIX_W;

  assign pixel = PIX_W'(slot_select(MAX_WORD_W'(word), int'(slot), PIX_W, PPW, LSB_FIRST));

endmodule

// File: rtl/pixel_fetch.sv
// Frame-buffer read path: pixel address -> packed-word RAM read with a
// one-word cache, valid/ready on request and pixel sides.
module pixel_fetch
  import fb_pkg::*;
#(
  parameter int WORD_W    = 16,
  parameter int PIX_W     = 4,
  parameter int ADDR_W    = 17,
  parameter int MEM_LAT   = 1,
  parameter bit LSB_FIRST = 1'b1,
  localparam int SEL_W    = sel_width(WORD_W, PIX_W),
  localparam int MADDR_W  = ADDR_W - SEL_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pix_req_valid,
  output logic               pix_req_ready,
  input  logic [ADDR_W-1:0]  pix_addr,
  input  logic               inval,
  output logic               mem_rd_en,
  output logic [MADDR_W-1:0] mem_addr,
  input  logic [WORD_W-1:0]  mem_rd_data,
  output logic               pix_out_valid,
  output logic [PIX_W-1:0]   pix_out,
  input  logic               pix_out_ready
);

  pix_fetch_state_t   state_reg;
  logic               cache_valid_reg;
  logic [MADDR_W-1:0] cache_tag_reg;
  logic [WORD_W-1:0]  cache_word_reg;
  logic [SEL_W-1:0]   slot_reg;
  logic [2:0]         cnt_reg;

  logic [MADDR_W-1:0] req_tag;
  logic [SEL_W-1:0]   req_slot;
  logic               accept;
  logic               hit;
  logic               capture;
  logic [WORD_W-1:0]  slice_word;
  logic [SEL_W-1:0]   slice_slot;
  logic [PIX_W-1:0]   slice_pix;

  assign req_tag  = pix_addr[ADDR_W-1:SEL_W];
  assign req_slot = pix_addr[SEL_W-1:0];

  assign pix_req_ready = (state_reg == READY) && (!pix_out_valid || pix_out_ready);
  assign accept        = pix_req_valid && pix_req_ready;
  assign hit           = cache_valid_reg && (cache_tag_reg == req_tag) && !inval;
  assign capture       = (state_reg == WAIT) && (cnt_reg == 3'd0);

  // One extractor serves both the cache (hits) and the RAM return (miss capture).
  assign slice_word = (state_reg == WAIT) ? mem_rd_data : cache_word_reg;
  assign slice_slot = (state_reg == WAIT) ? slot_reg : req_slot;

  pixel_slice #(
    .WORD_W    (WORD_W),
    .PIX_W     (PIX_W),
    .LSB_FIRST (LSB_FIRST)
  ) u_slice (
    .word  (slice_word),
    .slot  (slice_slot),
    .pixel (slice_pix)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= READY;
      cache_valid_reg <= 1'b0;
      cache_tag_reg   <= '0;
      cache_word_reg  <= '0;
      slot_reg        <= '0;
      cnt_reg         <= 3'd0;
      mem_rd_en       <= 1'b0;
      mem_addr        <= '0;
      pix_out_valid   <= 1'b0;
      pix_out         <= '0;
    end else begin
      mem_rd_en <= 1'b0;
      if (pix_out_valid && pix_out_ready) pix_out_valid <= 1'b0;
      if (inval) cache_valid_reg <= 1'b0;

      case (state_reg)
        READY: begin
          if (accept) begin
            if (hit) begin
              pix_out       <= slice_pix;
              pix_out_valid <= 1'b1;
            end else begin
              mem_rd_en <= 1'b1;
              mem_addr  <= req_tag;
              slot_reg  <= req_slot;
              cnt_reg   <= 3'(MEM_LAT);
              state_reg <= WAIT;
            end
          end
        end
        WAIT: begin
          if (capture) begin
            // mem_addr still holds the tag of the outstanding read; a
            // coincident inval keeps the fresh word unusable for later hits.
            cache_word_reg  <= mem_rd_data;
            cache_tag_reg   <= mem_addr;
            cache_valid_reg <= !inval;
            pix_out         <= slice_pix;
            pix_out_valid   <= 1'b1;
            state_reg       <= READY;
          end else begin
            cnt_reg <= cnt_reg - 3'd1;
          end
        end
        default: state_reg <= READY;
      endcase
    end
  end

endmodule
